// File: rtl/mdu_hilo_ctrl_if.sv
// Handshake between the HI/LO controller (master) and the shift-add multiplier (slave).
interface mdu_hilo_ctrl_if;
    logic        mult_begin;
    logic [31:0] mult_op1;
    logic [31:0] mult_op2;
    logic [63:0] mult_product;
    logic        mult_end;

    modport master (
        output mult_begin, mult_op1, mult_op2,
        input  mult_product, mult_end
    );

    modport slave (
        input  mult_begin, mult_op1, mult_op2,
        output mult_product, mult_end
    );
endinterface

// File: rtl/mdu_hilo_ctrl.sv
// EX-stage multiply controller and HI/LO register file with flush abort and busy watchdog.
// Optional MTHI/MTLO write path is enabled by defining MDU_MTHILO_EN.
module mdu_hilo_ctrl #(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ex_mult,
    input  logic signed [31:0] ex_op1,
    input  logic signed [31:0] ex_op2,
    input  logic               ex_mfhi,
    input  logic               ex_mflo,
    input  logic               ex_flush,
    output logic               mdu_stall,
    output logic [31:0]        hi,
    output logic [31:0]        lo,
    output logic               mdu_err,
`ifdef MDU_MTHILO_EN
    input  logic               ex_mthi,
    input  logic               ex_mtlo,
    input  logic [31:0]        ex_wdata,
`endif
    mdu_hilo_ctrl_if.master    mul
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    state_t              state;
    logic [CNT_W-1:0]    busy_cnt;
    logic                mult_begin_r;
    logic signed [31:0]  op1_r;
    logic signed [31:0]  op2_r;
    logic signed [63:0]  product_s;
    logic                busy;
    logic                hilo_rd_wait;
    logic                hilo_wr_wait;

    assign product_s      = $signed(mul.mult_product);
    assign mul.mult_begin = mult_begin_r;
    assign mul.mult_op1   = op1_r;
    assign mul.mult_op2   = op2_r;

    assign busy = (state == S_BUSY);

    // HI/LO readers wait while a product is pending; kept explicit even though BUSY already stalls.
    always_comb begin
        hilo_rd_wait = busy & (ex_mfhi | ex_mflo);
        hilo_wr_wait = 1'b0;
`ifdef MDU_MTHILO_EN
        hilo_wr_wait = busy & (ex_mthi | ex_mtlo);
`endif
        mdu_stall = ((state == S_IDLE) & ex_mult & ~ex_flush)
                  | busy
                  | hilo_rd_wait
                  | hilo_wr_wait;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            hi           <= '0;
            lo           <= '0;
            mult_begin_r <= 1'b0;
            op1_r        <= '0;
            op2_r        <= '0;
            busy_cnt     <= '0;
            mdu_err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    busy_cnt <= '0;
                    if (ex_mult && !ex_flush) begin
                        op1_r        <= ex_op1;
                        op2_r        <= ex_op2;
                        mult_begin_r <= 1'b1;
                        state        <= S_BUSY;
                    end
`ifdef MDU_MTHILO_EN
                    else if (!ex_flush) begin
                        if (ex_mthi) hi <= ex_wdata;
                        if (ex_mtlo) lo <= ex_wdata;
                    end
`endif
                end

                // Flush wins over a same-cycle product; watchdog fires only if no product arrived.
                S_BUSY: begin
                    if (ex_flush) begin
                        mult_begin_r <= 1'b0;
                        busy_cnt     <= '0;
                        state        <= S_IDLE;
                    end else if (mul.mult_end) begin
                        hi           <= product_s[63:32];
                        lo           <= product_s[31:0];
                        mult_begin_r <= 1'b0;
                        busy_cnt     <= busy_cnt + 1'b1;
                        state        <= S_DONE;
                    end else if (busy_cnt == CNT_LAST) begin
                        mdu_err      <= 1'b1;
                        mult_begin_r <= 1'b0;
                        busy_cnt     <= '0;
                        state        <= S_IDLE;
                    end else begin
                        busy_cnt     <= busy_cnt + 1'b1;
                    end
                end

                // One idle-handshake cycle so the multiplier cannot restart on the retiring MULT.
                S_DONE: begin
                    busy_cnt <= '0;
                    state    <= S_IDLE;
                end

                default: begin
                    mult_begin_r <= 1'b0;
                    busy_cnt     <= '0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_hilo_ctrl.sv
// Directed bench for mdu_hilo_ctrl with a behavioural shift-add multiplier timing model.
module tb_mdu_hilo_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ex_mult;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic        ex_mfhi;
    logic        ex_mflo;
    logic        ex_flush;
    logic        mdu_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mdu_err;
`ifdef MDU_MTHILO_EN
    logic        ex_mthi;
    logic        ex_mtlo;
    logic [31:0] ex_wdata;
`endif

    int n_pass  = 0;
    int n_total = 0;
    bit stub_mult = 1'b0;
    int mcnt;

    mdu_hilo_ctrl_if mif ();

    mdu_hilo_ctrl #(.MAX_CYCLES(40), .CNT_W(6)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .ex_mult   (ex_mult),
        .ex_op1    (ex_op1),
        .ex_op2    (ex_op2),
        .ex_mfhi   (ex_mfhi),
        .ex_mflo   (ex_mflo),
        .ex_flush  (ex_flush),
        .mdu_stall (mdu_stall),
        .hi        (hi),
        .lo        (lo),
        .mdu_err   (mdu_err),
`ifdef MDU_MTHILO_EN
        .ex_mthi   (ex_mthi),
        .ex_mtlo   (ex_mtlo),
        .ex_wdata  (ex_wdata),
`endif
        .mul       (mif)
    );

    always #5 clk = ~clk;

    // Multiplier model: done strobe on the (m+3)th cycle of mult_begin, m = MSB index of |op2|.
    function automatic int msb_idx(input logic [31:0] v);
        logic [31:0] a;
        a = v[31] ? (~v + 32'd1) : v;
        for (int i = 31; i >= 0; i--) if (a[i]) return i;
        return -1;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn || !mif.mult_begin) mcnt <= 0;
        else                            mcnt <= mcnt + 1;
    end

    assign mif.mult_end = !stub_mult && mif.mult_begin && (mcnt == msb_idx(mif.mult_op2) + 2);
    assign mif.mult_product = {{32{mif.mult_op1[31]}}, mif.mult_op1} * {{32{mif.mult_op2[31]}}, mif.mult_op2};

    // Issue one MULT and count stalled cycles; returns in the first unstalled cycle.
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input bit hold, output int n);
        @(negedge clk);
        ex_op1  = a;
        ex_op2  = b;
        ex_mult = 1'b1;
        #1;
        n = 0;
        while (mdu_stall && n < 200) begin
            n++;
            @(negedge clk);
            if (!hold) ex_mult = 1'b0;
            #1;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; ex_mult = 0; ex_op1 = 0; ex_op2 = 0; ex_mfhi = 0; ex_mflo = 0; ex_flush = 0;
`ifdef MDU_MTHILO_EN
        ex_mthi = 0; ex_mtlo = 0; ex_wdata = 0;
`endif
        #12;
        n_total++; if (mdu_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", mdu_stall); else n_pass++;
        n_total++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo); else n_pass++;
        n_total++; if (mdu_err !== 1'b0) $display("FAIL reset_err got %b want 0", mdu_err); else n_pass++;
        n_total++; if (mif.mult_begin !== 1'b0 || mif.mult_op1 !== 32'h0 || mif.mult_op2 !== 32'h0)
            $display("FAIL reset_mult got %b %h %h want 0 0 0", mif.mult_begin, mif.mult_op1, mif.mult_op2); else n_pass++;
        @(negedge clk); resetn = 1'b1;
    endtask

    task automatic test_basic();
        int n;
        do_mult(32'd3, 32'd5, 1'b1, n);
        n_total++; if (n !== 6) $display("FAIL basic_stall got %0d want 6", n); else n_pass++;
        n_total++; if (hi !== 32'h0 || lo !== 32'hF) $display("FAIL basic_hilo got %h/%h want 00000000/0000000f", hi, lo); else n_pass++;
        n_total++; if (mif.mult_begin !== 1'b0 || mdu_stall !== 1'b0)
            $display("FAIL basic_done got begin=%b stall=%b want 0 0", mif.mult_begin, mdu_stall); else n_pass++;
        @(negedge clk); ex_mult = 1'b0; #1;
        n_total++; if (mif.mult_begin !== 1'b0 || mdu_stall !== 1'b0)
            $display("FAIL basic_no_restart got begin=%b stall=%b want 0 0", mif.mult_begin, mdu_stall); else n_pass++;
    endtask

    task automatic test_negative();
        int n;
        do_mult(32'hFFFFFFFE, 32'd3, 1'b0, n);
        n_total++; if (n !== 5) $display("FAIL neg_stall got %0d want 5", n); else n_pass++;
        n_total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) $display("FAIL neg_hilo got %h/%h want ffffffff/fffffffa", hi, lo); else n_pass++;
    endtask

    task automatic test_flush();
        int n;
        // Flush in the 3rd BUSY cycle, then flush on the very cycle the product arrives.
        for (int run = 0; run < 2; run++) begin
            @(negedge clk); ex_op1 = 32'd3; ex_op2 = 32'd5; ex_mult = 1'b1;
            for (int k = 1; k <= (run == 0 ? 3 : 5); k++) begin
                @(negedge clk); ex_mult = 1'b0;
            end
            ex_flush = 1'b1; #1;
            n_total++; if (mdu_stall !== 1'b1) $display("FAIL flush%0d_busy got %b want 1", run, mdu_stall); else n_pass++;
            @(negedge clk); ex_flush = 1'b0; #1;
            n_total++; if (mdu_stall !== 1'b0 || mif.mult_begin !== 1'b0)
                $display("FAIL flush%0d_idle got stall=%b begin=%b want 0 0", run, mdu_stall, mif.mult_begin); else n_pass++;
            n_total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA)
                $display("FAIL flush%0d_hilo got %h/%h want ffffffff/fffffffa", run, hi, lo); else n_pass++;
        end
        do_mult(32'd2, 32'd2, 1'b0, n);
        n_total++; if (n !== 5 || hi !== 32'h0 || lo !== 32'h4)
            $display("FAIL flush_next got n=%0d %h/%h want 5 00000000/00000004", n, hi, lo); else n_pass++;
    endtask

    task automatic test_minint_zero();
        int n;
        do_mult(32'h80000000, 32'd2, 1'b0, n);
        n_total++; if (n !== 5 || hi !== 32'hFFFFFFFF || lo !== 32'h0)
            $display("FAIL minint got n=%0d %h/%h want 5 ffffffff/00000000", n, hi, lo); else n_pass++;
        do_mult(32'd7, 32'd0, 1'b0, n);
        n_total++; if (n !== 3) $display("FAIL zero_stall got %0d want 3", n); else n_pass++;
        n_total++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL zero_hilo got %h/%h want 0/0", hi, lo); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n;
        ex_mfhi = 1'b1;
        do_mult(32'h00010000, 32'h00010000, 1'b0, n);
        n_total++; if (n !== 20) $display("FAIL mfhi_stall got %0d want 20", n); else n_pass++;
        n_total++; if (mdu_stall !== 1'b0) $display("FAIL mfhi_done_stall got %b want 0", mdu_stall); else n_pass++;
        n_total++; if (hi !== 32'h1 || lo !== 32'h0) $display("FAIL mfhi_hilo got %h/%h want 00000001/00000000", hi, lo); else n_pass++;
        ex_mfhi = 1'b0;
        do_mult(32'd3, 32'd5, 1'b0, n);
        n_total++; if (n !== 6 || hi !== 32'h0 || lo !== 32'hF)
            $display("FAIL b2b got n=%0d %h/%h want 6 00000000/0000000f", n, hi, lo); else n_pass++;
    endtask

    task automatic test_idle_flush();
        @(negedge clk); ex_op1 = 32'h1234; ex_op2 = 32'd9; ex_mult = 1'b1; ex_flush = 1'b1; #1;
        n_total++; if (mdu_stall !== 1'b0) $display("FAIL idle_flush_stall got %b want 0", mdu_stall); else n_pass++;
        @(negedge clk); ex_mult = 1'b0; ex_flush = 1'b0; #1;
        n_total++; if (mif.mult_begin !== 1'b0 || mif.mult_op1 !== 32'h3)
            $display("FAIL idle_flush_latch got begin=%b op1=%h want 0 00000003", mif.mult_begin, mif.mult_op1); else n_pass++;
    endtask

`ifdef MDU_MTHILO_EN
    task automatic test_mthilo();
        int n;
        @(negedge clk); ex_mthi = 1'b1; ex_wdata = 32'hDEADBEEF; #1;
        n_total++; if (mdu_stall !== 1'b0) $display("FAIL mthi_stall got %b want 0", mdu_stall); else n_pass++;
        @(negedge clk); ex_mthi = 1'b0; #1;
        n_total++; if (hi !== 32'hDEADBEEF) $display("FAIL mthi_write got %h want deadbeef", hi); else n_pass++;
        @(negedge clk); ex_mtlo = 1'b1; ex_flush = 1'b1; ex_wdata = 32'h55AA55AA;
        @(negedge clk); ex_mtlo = 1'b0; ex_flush = 1'b0; #1;
        n_total++; if (lo !== 32'hF) $display("FAIL mtlo_flush got %h want 0000000f", lo); else n_pass++;
        @(negedge clk); ex_op1 = 32'd2; ex_op2 = 32'd2; ex_mult = 1'b1; ex_mthi = 1'b1; ex_wdata = 32'hCAFEF00D;
        @(negedge clk); ex_mult = 1'b0; ex_mthi = 1'b0; #1;
        n_total++; if (hi !== 32'hDEADBEEF || mdu_stall !== 1'b1)
            $display("FAIL mult_over_mthi got %h stall=%b want deadbeef 1", hi, mdu_stall); else n_pass++;
        n = 0;
        while (mdu_stall && n < 200) begin n++; @(negedge clk); #1; end
        n_total++; if (hi !== 32'h0 || lo !== 32'h4) $display("FAIL mult_over_mthi_res got %h/%h want 0/4", hi, lo); else n_pass++;
        @(negedge clk); ex_op1 = 32'd3; ex_op2 = 32'd5; ex_mult = 1'b1;
        @(negedge clk); ex_mult = 1'b0; ex_mtlo = 1'b1; ex_wdata = 32'h12345678; #1;
        n = 1;
        while (mdu_stall && n < 200) begin n++; @(negedge clk); #1; end
        n_total++; if (n !== 6 || lo !== 32'hF) $display("FAIL mtlo_busy got n=%0d lo=%h want 6 0000000f", n, lo); else n_pass++;
        @(negedge clk); #1;
        n_total++; if (mdu_stall !== 1'b0 || lo !== 32'hF) $display("FAIL mtlo_idle got stall=%b lo=%h want 0 0000000f", mdu_stall, lo); else n_pass++;
        @(negedge clk); ex_mtlo = 1'b0; #1;
        n_total++; if (lo !== 32'h12345678) $display("FAIL mtlo_write got %h want 12345678", lo); else n_pass++;
    endtask
`endif

    task automatic test_watchdog();
        int n;
        do_mult(32'hFFFFFFFF, 32'd7, 1'b0, n);
        n_total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF9 || mdu_err !== 1'b0)
            $display("FAIL wd_pre got %h/%h err=%b want ffffffff/fffffff9 0", hi, lo, mdu_err); else n_pass++;
        stub_mult = 1'b1;
        do_mult(32'd3, 32'd5, 1'b0, n);
        n_total++; if (n !== 41) $display("FAIL wd_stall got %0d want 41", n); else n_pass++;
        n_total++; if (mdu_err !== 1'b1 || mif.mult_begin !== 1'b0)
            $display("FAIL wd_err got err=%b begin=%b want 1 0", mdu_err, mif.mult_begin); else n_pass++;
        n_total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF9)
            $display("FAIL wd_hilo got %h/%h want ffffffff/fffffff9", hi, lo); else n_pass++;
        stub_mult = 1'b0;
        do_mult(32'd2, 32'd2, 1'b0, n);
        n_total++; if (n !== 5 || lo !== 32'h4 || mdu_err !== 1'b1)
            $display("FAIL wd_sticky got n=%0d lo=%h err=%b want 5 00000004 1", n, lo, mdu_err); else n_pass++;
    endtask

    task automatic test_reset_busy();
        @(negedge clk); ex_op1 = 32'h00010000; ex_op2 = 32'h00010000; ex_mult = 1'b1;
        @(negedge clk); ex_mult = 1'b0;
        @(negedge clk); #1;
        n_total++; if (mif.mult_begin !== 1'b1) $display("FAIL rst_busy_pre got %b want 1", mif.mult_begin); else n_pass++;
        resetn = 1'b0; #1;
        n_total++; if (mif.mult_begin !== 1'b0 || mdu_stall !== 1'b0 || mdu_err !== 1'b0)
            $display("FAIL rst_busy_ctrl got begin=%b stall=%b err=%b want 0 0 0", mif.mult_begin, mdu_stall, mdu_err); else n_pass++;
        n_total++; if (hi !== 32'h0 || lo !== 32'h0 || mif.mult_op1 !== 32'h0)
            $display("FAIL rst_busy_data got %h/%h op1=%h want 0/0 0", hi, lo, mif.mult_op1); else n_pass++;
        @(negedge clk); resetn = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        n_total++; if (mif.mult_begin !== 1'b0 || mdu_stall !== 1'b0)
            $display("FAIL rst_busy_after got begin=%b stall=%b want 0 0", mif.mult_begin, mdu_stall); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_flush();
        test_minint_zero();
        test_back_to_back();
        test_idle_flush();
`ifdef MDU_MTHILO_EN
        test_mthilo();
`endif
        test_watchdog();
        test_reset_busy();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mdu_hilo_ctrl.md
Name: mdu_hilo_ctrl

Overview:
Execute-stage multiply controller and HI/LO register file, one stage upstream and downstream of the shift-add `multiply` unit.
- Accepts MULT requests from EX and latches the operands.
- Drives the multiplier handshake (`mult_begin` held high until `mult_end`) and captures the 64-bit product into HI/LO.
- Stalls the pipeline while busy; also stalls MFHI/MFLO while HI/LO is pending.
- Supports flush abort and a watchdog on runaway multiplies.

Parameters:
MAX_CYCLES, 40, BUSY-state cycle limit before the watchdog aborts and flags `mdu_err`.
CNT_W, 6, width of the busy-cycle counter; must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
ex_mult  in  1  MULT instruction valid in EX (signed)
ex_op1  in  32  rs operand
ex_op2  in  32  rt operand
ex_mfhi  in  1  MFHI in EX
ex_mflo  in  1  MFLO in EX
ex_flush  in  1  cancel the EX instruction (exception/branch kill)
mdu_stall  out  1  freeze IF/ID/EX
hi  out  32  HI register
lo  out  32  LO register
mdu_err  out  1  sticky watchdog error
mult_begin  out  1  to multiplier
mult_op1  out  32  to multiplier, latched rs
mult_op2  out  32  to multiplier, latched rt
mult_product  in  64  from multiplier, signed result
mult_end  in  1  from multiplier, one-cycle done strobe
(Optional feature adds ex_mthi, ex_mtlo, ex_wdata; see below.)

Behaviour:
- Reset (async, resetn=0): state=IDLE; hi=0, lo=0; mult_begin=0; mult_op1=0, mult_op2=0; counter=0; mdu_err=0. mdu_stall is combinational and therefore 0 in IDLE with no request.
- States:
  - IDLE: on ex_mult & ~ex_flush, latch ex_op1/ex_op2 into mult_op1/mult_op2 and go to BUSY. ex_flush with ex_mult: stay IDLE, latch nothing.
  - BUSY: mult_begin=1, and counter increments each cycle.
    - mult_end=1: hi<=mult_product[63:32], lo<=mult_product[31:0], go to DONE.
    - ex_flush=1, which has priority over mult_end: go to IDLE, leave HI/LO unchanged, drop mult_begin.
    - counter==MAX_CYCLES-1 without mult_end: set mdu_err=1, go to IDLE, leave HI/LO unchanged.
  - DONE: mult_begin=0 for exactly one cycle, so the multiplier does not reload. ex_mult is ignored here (it is the same, now-retiring instruction). Go to IDLE and clear the counter.
- mdu_stall = (IDLE & ex_mult & ~ex_flush) | BUSY | (BUSY & (ex_mfhi|ex_mflo)). The last term is subsumed but kept explicit for verification.
- mdu_stall=0 in DONE. The MULT instruction leaves EX at the DONE edge. An MFHI/MFLO in the next instruction reads the new hi/lo directly (registered outputs, no bypass required).
- mult_op1/mult_op2 stay constant for the whole BUSY period. The multiplier re-samples operand signs every valid cycle.
- Latency with the request first seen at cycle 0:
  - mdu_stall is high for (m+4) cycles, where m is the bit index of the MSB of |op2|, with m=-1 for op2=0.
  - HI/LO update at the last stalled edge.
- Back-to-back MULT: the second request is accepted in the IDLE cycle after DONE.
- mdu_err is sticky until reset.
- Reset mid-BUSY: immediate return to reset values. The multiplier must see mult_begin=0.

Optional Feature:
MDU_MTHILO_EN
- Defined:
  - Adds ports ex_mthi, ex_mtlo (in, 1) and ex_wdata (in, 32).
  - In IDLE with ~ex_flush: ex_mthi writes hi<=ex_wdata and ex_mtlo writes lo<=ex_wdata at the next edge.
  - In BUSY, MTHI/MTLO stall (added to mdu_stall) until DONE.
  - ex_mult has priority over simultaneous ex_mthi/ex_mtlo, which are ignored.
- Undefined: the ports are absent, and HI/LO are written only by multiply results.

Test Plan:
1. ex_mult, op1=3, op2=5 -> stall 6 cycles; hi=0x00000000, lo=0x0000000F; DONE cycle has stall=0, mult_begin=0.
2. op1=0xFFFFFFFE (-2), op2=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; stall 5 cycles.
3. op1=0x80000000, op2=2 -> hi=0xFFFFFFFF, lo=0x00000000. Then op1=7, op2=0 -> stall 3 cycles, hi=lo=0.
4. MULT 3*5 with ex_flush pulsed in the 3rd BUSY cycle -> IDLE next cycle, hi/lo keep prior values, mult_begin drops. A new MULT 2*2 accepted later -> lo=4.
5. MFHI asserted with MULT op1=0x10000, op2=0x10000 -> stall holds until DONE; then hi=0x00000001, lo=0. Back-to-back MULT accepted exactly one cycle after DONE.
6. MDU_MTHILO_EN defined: MTHI 0xDEADBEEF in IDLE -> hi=0xDEADBEEF next edge. MTLO during BUSY -> stalled, no write until after DONE. Also hold mult_end=0 (stub multiplier) -> mdu_err=1 after 40 BUSY cycles, state returns to IDLE.
